bmem_line_adapter: RTL and testbench

Initiator-side adapter between the last-level cache and the burst memory port of `mp4`. Converts one 256-bit cache-line read or write into a 4-beat, 64-bit burst on the `bmem_*` interface, then returns a single-cycle line response to the cache. The adapter sits at the top of `mp4` and drives `bmem_address`, `bmem_read`, `bmem_write` and `bmem_wdata` directly.

---
 rtl/bmem_line_adapter.sv | 148 ++++++++++++++
 tb/tb_bmem_line_adapter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_line_adapter.sv
// Cache-line to 4-beat burst adapter for the mp4 bmem port.
// Optional watchdog/protocol error: BMEM_LINE_ADAPTER_TIMEOUT_EN.
module bmem_line_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_addr,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  bmem_address,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_resp,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_BEAT, WR_BURST, WR_WAIT, DONE
  } state_e;

  state_e         state_q;
  logic [1:0]     beat_q;
  logic [255:0]   line_q;
  logic [255:0]   rdata_q;
  logic [31:0]    addr_q;
  logic [63:0]    wdata_q;
  logic           read_q;
  logic           write_q;
  logic           resp_q;
  logic           unused_addr;

  assign unused_addr  = ^line_addr[4:0];
  assign line_rdata   = rdata_q;
  assign line_resp    = resp_q;
  assign bmem_address = addr_q;
  assign bmem_read    = read_q;
  assign bmem_write   = write_q;
  assign bmem_wdata   = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      line_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Write has priority; a held read is picked up afterwards.
          if (line_write) begin
            addr_q  <= {line_addr[31:5], 5'b0};
            line_q  <= line_wdata;
            wdata_q <= line_wdata[63:0];
            write_q <= 1'b1;
            beat_q  <= 2'd0;
            state_q <= WR_BURST;
          end else if (line_read) begin
            addr_q  <= {line_addr[31:5], 5'b0};
            read_q  <= 1'b1;
            beat_q  <= 2'd0;
            state_q <= RD_CMD;
          end
        end
        RD_CMD: begin
          read_q  <= 1'b0;
          state_q <= RD_BEAT;
        end
        RD_BEAT: begin
          if (bmem_resp) begin
            rdata_q[{beat_q, 6'd0} +: 64] <= bmem_rdata;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (beat_q == 2'd3) begin
            write_q <= 1'b0;
            beat_q  <= 2'd0;
            state_q <= WR_WAIT;
          end else begin
            beat_q  <= beat_q + 2'd1;
            wdata_q <= line_q[{beat_q + 2'd1, 6'd0} +: 64];
          end
        end
        WR_WAIT: begin
          if (bmem_resp) begin
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BMEM_LINE_ADAPTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          wait_st;

  assign wait_st = (state_q == RD_BEAT) || (state_q == WR_WAIT);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!wait_st || bmem_resp) begin
        cnt_q <= '0;
      end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // Timeout, or a response the FSM is not waiting for.
      if (wait_st && !bmem_resp && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        err_q <= 1'b1;
      end
      if (!wait_st && bmem_resp) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned unused_tmo = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed + randomized bench for bmem_line_adapter with a
// behavioural burst-memory model driven from one initial block.
module tb_bmem_line_adapter;

`ifdef BMEM_LINE_ADAPTER_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 1024;
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  line_addr = '0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_resp = 1'b0;
  logic         err;

  int   checks  = 0;
  int   errors  = 0;
  logic err_exp = 1'b0;

  bmem_line_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read),
    .line_write(line_write), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench hung");
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd"},  bmem_read, 0);
    chk({tag, ".wr"},  bmem_write, 0);
    chk({tag, ".adr"}, bmem_address, 0);
    chk({tag, ".wd"},  bmem_wdata, 0);
    chk({tag, ".rsp"}, line_resp, 0);
    chk({tag, ".ld"},  line_rdata, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Memory model for one read burst; abort_after<4 resets mid-burst.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [255:0] line, input int gmax,
                         input int abort_after);
    int n;
    int resps;
    int g;
    line_addr = addr;
    line_read = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bmem_read && n < 50);
    chk({tag, ".cmd"}, bmem_read, 1);
    chk({tag, ".lat"}, n, 1);
    chk({tag, ".adr"}, bmem_address, {addr[31:5], 5'b0});
    @(posedge clk); #1;
    chk({tag, ".pulse"}, bmem_read, 0);
    resps = 0;
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(gmax, 0);
      repeat (g) begin
        bmem_resp  = 1'b0;
        bmem_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
        resps += int'(line_resp);
      end
      if (i == abort_after) begin
        bmem_resp = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero({tag, ".rstz"});
        @(posedge clk); #1;
        line_read = 1'b0;
        rst = 1'b1;
        return;
      end
      bmem_resp  = 1'b1;
      bmem_rdata = line[64*i +: 64];
      @(posedge clk); #1;
      if (i < 3) resps += int'(line_resp);
    end
    bmem_resp = 1'b0;
    chk({tag, ".early"}, resps, 0);
    chk({tag, ".resp"}, line_resp, 1);
    chk({tag, ".data"}, line_rdata, line);
    line_read = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".resp1"}, line_resp, 0);
    chk({tag, ".hold"}, line_rdata, line);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [255:0] line, input int gap);
    int n;
    line_addr  = addr;
    line_wdata = line;
    line_write = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bmem_write && n < 50);
    chk({tag, ".lat"}, n, 1);
    for (int k = 0; k < 4; k++) begin
      chk({tag, ".wr"}, bmem_write, 1);
      chk({tag, ".wd"}, bmem_wdata, line[64*k +: 64]);
      chk({tag, ".adr"}, bmem_address, {addr[31:5], 5'b0});
      @(posedge clk); #1;
    end
    chk({tag, ".wr_end"}, bmem_write, 0);
    for (int j = 1; j <= gap; j++) begin
      bmem_resp = 1'b0;
      @(posedge clk); #1;
      if (TMO_EN && j >= TMO) err_exp = 1'b1;
      chk({tag, ".gap_rsp"}, line_resp, 0);
      chk({tag, ".gap_err"}, err, err_exp);
    end
    bmem_resp = 1'b1;
    @(posedge clk); #1;
    bmem_resp = 1'b0;
    chk({tag, ".resp"}, line_resp, 1);
    line_write = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".resp1"}, line_resp, 0);
    chk({tag, ".bubble"}, bmem_read, 0);
    chk({tag, ".wr_idle"}, bmem_write, 0);
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read("rd_dir", 32'h6000_0024, l, 0, 4);

    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_write("wr_dir", 32'h1234_5678, l, 3);

    for (int i = 0; i < 5; i++) begin
      do_read("rd_rnd", $urandom, rnd_line(), 5, 4);
    end

    for (int i = 0; i < 3; i++) begin
      do_write("wr_rnd", $urandom, rnd_line(), $urandom_range(6, 0));
    end

    a = $urandom;
    line_read = 1'b1;
    do_write("both_wr", a, rnd_line(), 1);
    do_read("both_rd", a, rnd_line(), 2, 4);

    a = $urandom;
    l = rnd_line();
    do_read("rd_abort", a, l, 2, 2);
    @(posedge clk); #1;
    do_read("rd_retry", a, l, 3, 4);

    do_write("wr_tmo", $urandom, rnd_line(), 20);

    bmem_resp = 1'b1;
    @(posedge clk); #1;
    bmem_resp = 1'b0;
    if (TMO_EN) err_exp = 1'b1;
    chk("stray.err", err, err_exp);
    chk("stray.rsp", line_resp, 0);
    chk("stray.rd", bmem_read, 0);
    @(posedge clk); #1;
    chk("stray.rsp1", line_resp, 0);

    #2 rst = 1'b0;
    #1 chk("rst.err", err, 0);
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_read("rd_final", $urandom, rnd_line(), 1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
